// File: rtl/uart_rx_debug.sv
// ---------------------------------------------------------------------------
// uart_rx_debug
//   8N1 UART receiver for the debug port. The asynchronous rx pin passes
//   through a two-flop synchroniser. The receiver validates the start bit at
//   its middle, then samples the eight data bits and the stop bit at mid-bit.
//   Each good byte is offered on a valid/ready interface that has a single
//   holding register.
//
//   Optional build macro: UART_RX_MAJORITY_EN
//     When defined, each data bit and the stop bit is the 2-of-3 majority of
//     rx_s taken at clk_cnt = CLKS_PER_BIT-3, -2 and -1. Start validation
//     still uses a single sample. The port list and timing are the same in
//     both builds.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line, asynchronous to clk, idle high
//   rx_data    out  received byte, stable while rx_valid=1
//   rx_valid   out  rx_data holds an unconsumed byte
//   rx_ready   in   consumer accepts; transfer on rx_valid & rx_ready
//   frame_err  out  one-cycle pulse: stop bit low, byte discarded
//   overrun    out  one-cycle pulse: new byte dropped, holding register full
// ---------------------------------------------------------------------------
module uart_rx_debug #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic        rx_meta_reg, rx_s_reg;
    logic [15:0] clk_cnt_reg, clk_cnt_next;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic [7:0]  rx_data_reg;
    logic        rx_valid_reg, frame_err_reg, overrun_reg;

    logic        half_done, bit_done, bit_sample;
    logic        shift_en, stop_good, stop_bad;

    assign half_done = (clk_cnt_reg == HALF_LAST);
    assign bit_done  = (clk_cnt_reg == BIT_LAST);

`ifdef UART_RX_MAJORITY_EN
    // The first two votes are taken just before the mid-bit sample. The third
    // vote is the live rx_s, so the decision lands on the same edge as the
    // single-sample build.
    localparam logic [15:0] VOTE_A = 16'(CLKS_PER_BIT - 3);
    localparam logic [15:0] VOTE_B = 16'(CLKS_PER_BIT - 2);
    logic vote_a_reg, vote_b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_a_reg <= 1'b1;
            vote_b_reg <= 1'b1;
        end else begin
            if (clk_cnt_reg == VOTE_A) vote_a_reg <= rx_s_reg;
            if (clk_cnt_reg == VOTE_B) vote_b_reg <= rx_s_reg;
        end
    end

    assign bit_sample = (vote_a_reg & vote_b_reg) | (vote_a_reg & rx_s_reg) |
                        (vote_b_reg & rx_s_reg);
`else
    assign bit_sample = rx_s_reg;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (!rx_s_reg) state_next = S_START;
            S_START: if (half_done) state_next = rx_s_reg ? S_IDLE : S_DATA;
            S_DATA:  if (bit_done && bit_idx_reg == 3'd7) state_next = S_STOP;
            // The receiver returns to IDLE at mid stop bit. This leaves half a
            // bit of margin to catch a back-to-back start edge.
            S_STOP:  if (bit_done) state_next = bit_sample ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s_reg) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        clk_cnt_next = 16'd0;
        shift_en     = 1'b0;
        stop_good    = 1'b0;
        stop_bad     = 1'b0;
        case (state_reg)
            S_START: clk_cnt_next = half_done ? 16'd0 : clk_cnt_reg + 16'd1;
            S_DATA: begin
                clk_cnt_next = bit_done ? 16'd0 : clk_cnt_reg + 16'd1;
                shift_en     = bit_done;
            end
            S_STOP: begin
                clk_cnt_next = bit_done ? 16'd0 : clk_cnt_reg + 16'd1;
                stop_good    = bit_done & bit_sample;
                stop_bad     = bit_done & ~bit_sample;
            end
            default: clk_cnt_next = 16'd0;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg   <= 1'b1;
            rx_s_reg      <= 1'b1;
            clk_cnt_reg   <= 16'd0;
            bit_idx_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            rx_data_reg   <= 8'd0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            clk_cnt_reg <= clk_cnt_next;

            if (state_reg == S_IDLE) bit_idx_reg <= 3'd0;
            else if (shift_en)       bit_idx_reg <= bit_idx_reg + 3'd1;

            // Data arrives LSB first, so each new bit enters at bit 7.
            if (shift_en) shift_reg <= {bit_sample, shift_reg[7:1]};

            // A byte can be loaded on the same edge that the consumer drains
            // the previous one.
            if (stop_good && (!rx_valid_reg || rx_ready)) begin
                rx_data_reg  <= shift_reg;
                rx_valid_reg <= 1'b1;
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end

            frame_err_reg <= stop_bad;
            overrun_reg   <= stop_good & rx_valid_reg & ~rx_ready;
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_debug.sv
module tb_uart_rx_debug;

    localparam int BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    uart_rx_debug #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // The monitor samples on the falling edge, away from the active edge.
    int         valid_cycles = 0;
    int         ferr_cycles  = 0;
    int         ovr_cycles   = 0;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        if (rx_valid) valid_cycles++;
        if (rx_valid && rx_ready) rx_log.push_back(rx_data);
        if (frame_err) ferr_cycles++;
        if (overrun) ovr_cycles++;
    end

    int pass_cnt  = 0;
    int total_cnt = 0;
    int b_valid, b_ferr, b_ovr, b_bytes;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_valid = valid_cycles;
        b_ferr  = ferr_cycles;
        b_ovr   = ovr_cycles;
        b_bytes = rx_log.size();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
        rx = stop_bit;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_bytes;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 0};
        vecs[3] = '{8'h5A, 1'b1, 1, 0};
        vecs[4] = '{8'h3C, 1'b0, 0, 1};
        vecs[5] = '{8'hC3, 1'b1, 1, 0};

        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b1;
        wait_clks(3);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        wait_clks(20);

        // Single frames with rx_ready held high.
        for (int v = 0; v < 6; v++) begin
            snap();
            send_frame(vecs[v].data, vecs[v].stop_bit);
            wait_clks(40);
            check($sformatf("vec%0d_bytes", v), rx_log.size() - b_bytes, vecs[v].exp_bytes);
            check($sformatf("vec%0d_valid_cycles", v), valid_cycles - b_valid, vecs[v].exp_bytes);
            check($sformatf("vec%0d_frame_err", v), ferr_cycles - b_ferr, vecs[v].exp_ferr);
            check($sformatf("vec%0d_overrun", v), ovr_cycles - b_ovr, 0);
            if (vecs[v].exp_bytes == 1 && rx_log.size() > b_bytes)
                check($sformatf("vec%0d_data", v), int'(rx_log[b_bytes]), int'(vecs[v].data));
            $display("vec%0d data=0x%0h stop=%0b bytes=%0d ferr=%0d", v, vecs[v].data,
                     vecs[v].stop_bit, rx_log.size() - b_bytes, ferr_cycles - b_ferr);
        end

        // False start: low for 4 clk, then back to idle.
        snap();
        rx = 1'b0;
        wait_clks(4);
        rx = 1'b1;
        wait_clks(40);
        check("false_start_valid", valid_cycles - b_valid, 0);
        check("false_start_ferr", ferr_cycles - b_ferr, 0);
        $display("false start: valid=%0d ferr=%0d", valid_cycles - b_valid, ferr_cycles - b_ferr);

        // Framing error followed by a break of 3 bit times, then a good frame.
        snap();
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        wait_clks(3 * BIT_CLKS);
        rx = 1'b1;
        wait_clks(32);
        send_frame(8'h55, 1'b1);
        wait_clks(40);
        check("break_ferr", ferr_cycles - b_ferr, 1);
        check("break_bytes", rx_log.size() - b_bytes, 1);
        if (rx_log.size() > b_bytes) check("break_next_data", int'(rx_log[b_bytes]), 'h55);
        $display("break: ferr=%0d bytes=%0d", ferr_cycles - b_ferr, rx_log.size() - b_bytes);

        // Overrun: two bytes with the consumer stalled.
        snap();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        wait_clks(20);
        send_frame(8'h22, 1'b1);
        wait_clks(40);
        check("ovr_pulses", ovr_cycles - b_ovr, 1);
        check("ovr_held_data", int'(rx_data), 'h11);
        check("ovr_held_valid", int'(rx_valid), 1);
        check("ovr_no_transfer", rx_log.size() - b_bytes, 0);
        rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_valid_drop", int'(rx_valid), 0);
        check("ovr_drained", rx_log.size() - b_bytes, 1);
        if (rx_log.size() > b_bytes) check("ovr_drained_data", int'(rx_log[b_bytes]), 'h11);
        $display("overrun: pulses=%0d held=0x%0h", ovr_cycles - b_ovr, rx_data);
        wait_clks(5);

        // Back-to-back frames with no idle gap between stop and next start.
        snap();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        wait_clks(40);
        check("b2b_bytes", rx_log.size() - b_bytes, 3);
        if (rx_log.size() >= b_bytes + 3) begin
            check("b2b_data0", int'(rx_log[b_bytes]), 'h00);
            check("b2b_data1", int'(rx_log[b_bytes + 1]), 'hFF);
            check("b2b_data2", int'(rx_log[b_bytes + 2]), 'h81);
        end
        check("b2b_flags", (ferr_cycles - b_ferr) + (ovr_cycles - b_ovr), 0);
        $display("back-to-back: bytes=%0d", rx_log.size() - b_bytes);

        // Reset in the middle of bit 4 of 0xF0.
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            wait_clks(BIT_CLKS);
        end
        rx = 1'b1;
        wait_clks(BIT_CLKS / 2);
        rst_n = 1'b0;
        #1;
        check("midreset_rx_data", int'(rx_data), 0);
        check("midreset_rx_valid", int'(rx_valid), 0);
        check("midreset_flags", int'(frame_err) + int'(overrun), 0);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(32);
        snap();
        send_frame(8'h81, 1'b1);
        wait_clks(40);
        check("postreset_bytes", rx_log.size() - b_bytes, 1);
        if (rx_log.size() > b_bytes) check("postreset_data", int'(rx_log[b_bytes]), 'h81);
        check("postreset_ferr", ferr_cycles - b_ferr, 0);
        $display("mid-frame reset: post bytes=%0d", rx_log.size() - b_bytes);

`ifdef UART_RX_MAJORITY_EN
        // A one-clock low glitch at the middle of bit 3 of 0xFF.
        snap();
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = 1'b1;
            if (i == 3) begin
                wait_clks(7);
                rx = 1'b0;
                wait_clks(1);
                rx = 1'b1;
                wait_clks(8);
            end else begin
                wait_clks(BIT_CLKS);
            end
        end
        rx = 1'b1;
        wait_clks(BIT_CLKS + 40);
        check("glitch_bytes", rx_log.size() - b_bytes, 1);
        if (rx_log.size() > b_bytes) check("glitch_data", int'(rx_log[b_bytes]), 'hFF);
        $display("majority glitch: bytes=%0d", rx_log.size() - b_bytes);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
